// File: rtl/pc_fetch_pkg.sv
// Shared constants, state encoding and helpers for the instruction-fetch front end.
package pc_fetch_pkg;

  localparam logic RST_ENABLE  = 1'b0;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic CHIP_DISA   = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_fetch_queue.sv
// Synchronous FIFO of {pc,inst} fetch words with clear; head is driven straight from storage registers.
module fetch_queue
  import pc_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [63:0]   data_i,
  output logic [CW-1:0] count_o,
  output logic          valid_o,
  output logic [63:0]   head_o
);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Clear wins over any same-cycle push or pop so wrong-path words never survive a redirect.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign count_o = count_q;
  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : {ZERO_WORD, ZERO_WORD};

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: PC register, fetch FSM, redirect muxing and the IF/ID fetch queue.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHK_EN.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ce,
  output logic [31:0] pc,
  input  logic [31:0] inst_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_tgt_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        fetch_err_o
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e  state_q;
  logic          ce_q;
  logic [31:0]   pc_q;
  logic [CW-1:0] q_count;
  logic [63:0]   q_head;
  logic          q_valid;
  logic          pop, push, redirect;
  logic [31:0]   redir_raw, redir_tgt;

  always_comb begin
    redir_raw = flush_i ? new_pc_i : branch_tgt_i;
    redirect  = 1'b0;
    case (state_q)
      FETCH_RUN:  redirect = flush_i | branch_flag_i;
      FETCH_HALT: redirect = flush_i;
      default:    redirect = 1'b0;
    endcase
  end

`ifdef FETCH_ALIGN_CHK_EN
  logic err_q;
  logic misalign;
  assign redir_tgt   = redir_raw;
  assign misalign    = |redir_raw[1:0];
  assign fetch_err_o = err_q;
`else
  assign redir_tgt   = word_align(redir_raw);
  assign fetch_err_o = 1'b0;
`endif

  assign pop  = q_valid & if_ready_i;
  assign push = ce_q & (state_q == FETCH_RUN) & ((q_count < CW'(QUEUE_DEPTH)) | pop) & ~redirect;

  // A full queue with no pop holds pc, so the ROM simply re-reads the same word.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= FETCH_IDLE;
      ce_q    <= CHIP_DISA;
      pc_q    <= RESET_PC;
`ifdef FETCH_ALIGN_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          state_q <= FETCH_RUN;
          ce_q    <= CHIP_ENABLE;
        end
        FETCH_RUN: begin
          if (redirect) begin
            pc_q <= redir_tgt;
`ifdef FETCH_ALIGN_CHK_EN
            if (misalign) begin
              state_q <= FETCH_HALT;
              ce_q    <= CHIP_DISA;
              err_q   <= 1'b1;
            end
`endif
          end else if (push) begin
            pc_q <= pc_q + PC_STEP;
          end
        end
`ifdef FETCH_ALIGN_CHK_EN
        FETCH_HALT: begin
          if (flush_i) begin
            pc_q <= redir_tgt;
            if (!misalign) begin
              state_q <= FETCH_RUN;
              ce_q    <= CHIP_ENABLE;
              err_q   <= 1'b0;
            end
          end
        end
`endif
        default: begin
          state_q <= FETCH_IDLE;
          ce_q    <= CHIP_DISA;
        end
      endcase
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .clear_i (redirect),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({pc_q, inst_i}),
    .count_o (q_count),
    .valid_o (q_valid),
    .head_o  (q_head)
  );

  assign ce         = ce_q;
  assign pc         = pc_q;
  assign if_valid_o = q_valid;
  assign if_pc_o    = q_head[63:32];
  assign if_inst_o  = q_head[31:0];

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed vector table, corner sequences and a random phase against a queue model.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst, ce, branch_flag_i, flush_i, if_valid_o, if_ready_i, fetch_err_o;
  logic [31:0] pc, inst_i, branch_tgt_i, new_pc_i, if_pc_o, if_inst_o;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {2'b00, a[31:2]} + 32'h100;
  endfunction

  assign inst_i = rom(pc);

  pc_fetch #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .inst_i(inst_i),
    .branch_flag_i(branch_flag_i), .branch_tgt_i(branch_tgt_i),
    .flush_i(flush_i), .new_pc_i(new_pc_i),
    .if_valid_o(if_valid_o), .if_ready_i(if_ready_i),
    .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .fetch_err_o(fetch_err_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: 0=IDLE 1=RUN 2=HALT; sb_q is the expected fetch queue contents.
  int          m_st = 0;
  logic        m_ce = 1'b0, m_err = 1'b0;
  logic [31:0] m_pc = 32'h0;
  logic [63:0] sb_q[$];
  logic [31:0] emitted[$];

  task automatic model_edge();
    logic [31:0] tgt;
    logic        pop, mis;
    int          sz;
    sz  = sb_q.size();
    pop = (sz != 0) && if_ready_i;
    if (pop) begin
      chk("sb_pc", if_pc_o, sb_q[0][63:32]);
      chk("sb_inst", if_inst_o, sb_q[0][31:0]);
    end
    if (if_valid_o && if_ready_i) emitted.push_back(if_pc_o);
    if (!rst) begin
      m_st = 0; m_ce = 1'b0; m_pc = 32'h0; m_err = 1'b0;
      sb_q.delete();
      return;
    end
    tgt = flush_i ? new_pc_i : branch_tgt_i;
    mis = (tgt[1:0] != 2'b00);
`ifndef FETCH_ALIGN_CHK_EN
    tgt[1:0] = 2'b00;
    mis = 1'b0;
`endif
    case (m_st)
      0: begin m_st = 1; m_ce = 1'b1; end
      1: begin
        if (flush_i || branch_flag_i) begin
          sb_q.delete();
          m_pc = tgt;
          if (mis) begin m_st = 2; m_ce = 1'b0; m_err = 1'b1; end
        end else begin
          if (pop) void'(sb_q.pop_front());
          if (sz < 2 || pop) begin
            sb_q.push_back({m_pc, rom(m_pc)});
            m_pc = m_pc + 32'd4;
          end
        end
      end
      default: begin
        if (pop) void'(sb_q.pop_front());
        if (flush_i) begin
          sb_q.delete();
          m_pc = tgt;
          if (!mis) begin m_st = 1; m_ce = 1'b1; m_err = 1'b0; end
        end
      end
    endcase
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("valid", 32'(if_valid_o), 32'(sb_q.size() != 0));
    chk("ce", 32'(ce), 32'(m_ce));
    chk("pc", pc, m_pc);
    chk("err", 32'(fetch_err_o), 32'(m_err));
    if (sb_q.size() != 0) chk("head_pc", if_pc_o, sb_q[0][63:32]);
  endtask

  typedef struct {
    logic rst, rdy, br; logic [31:0] tgt; logic fl; logic [31:0] npc;
    logic e_v; logic [31:0] e_ipc; logic e_ce; logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rdy, input logic br, input logic [31:0] tgt,
                              input logic fl, input logic [31:0] npc, input logic ev,
                              input logic [31:0] eipc, input logic ece, input logic [31:0] epc);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.br = br; v.tgt = tgt; v.fl = fl; v.npc = npc;
    v.e_v = ev; v.e_ipc = eipc; v.e_ce = ece; v.e_pc = epc;
    return v;
  endfunction

  vec_t vt[14];

  initial begin
    int hits;
    vt[0]  = mk(0, 0, 0, 0,     0, 0,     0, 32'h0,   0, 32'h0);
    vt[1]  = mk(1, 0, 0, 0,     0, 0,     0, 32'h0,   1, 32'h0);
    vt[2]  = mk(1, 0, 0, 0,     0, 0,     1, 32'h0,   1, 32'h4);
    vt[3]  = mk(1, 0, 0, 0,     0, 0,     1, 32'h0,   1, 32'h8);
    vt[4]  = mk(1, 0, 0, 0,     0, 0,     1, 32'h0,   1, 32'h8);
    vt[5]  = mk(1, 0, 0, 0,     0, 0,     1, 32'h0,   1, 32'h8);
    vt[6]  = mk(1, 0, 0, 0,     0, 0,     1, 32'h0,   1, 32'h8);
    vt[7]  = mk(1, 1, 0, 0,     0, 0,     1, 32'h4,   1, 32'hC);
    vt[8]  = mk(1, 0, 1, 32'h40, 0, 0,    0, 32'h0,   1, 32'h40);
    vt[9]  = mk(1, 1, 0, 0,     0, 0,     1, 32'h40,  1, 32'h44);
    vt[10] = mk(1, 1, 0, 0,     0, 0,     1, 32'h44,  1, 32'h48);
    vt[11] = mk(1, 1, 1, 32'h40, 1, 32'h180, 0, 32'h0, 1, 32'h180);
    vt[12] = mk(1, 1, 0, 0,     0, 0,     1, 32'h180, 1, 32'h184);
    vt[13] = mk(1, 1, 0, 0,     0, 0,     1, 32'h184, 1, 32'h188);

    rst = 1'b0; if_ready_i = 1'b0; branch_flag_i = 1'b0; flush_i = 1'b0;
    branch_tgt_i = 32'h0; new_pc_i = 32'h0;

    for (int i = 0; i < 14; i++) begin
      rst = vt[i].rst; if_ready_i = vt[i].rdy; branch_flag_i = vt[i].br;
      branch_tgt_i = vt[i].tgt; flush_i = vt[i].fl; new_pc_i = vt[i].npc;
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(if_valid_o), 32'(vt[i].e_v));
      chk($sformatf("tbl%0d_ce", i), 32'(ce), 32'(vt[i].e_ce));
      chk($sformatf("tbl%0d_pc", i), pc, vt[i].e_pc);
      chk($sformatf("tbl%0d_err", i), 32'(fetch_err_o), 32'h0);
      if (vt[i].e_v || !vt[i].rst) begin
        chk($sformatf("tbl%0d_ifpc", i), if_pc_o, vt[i].e_ipc);
        chk($sformatf("tbl%0d_inst", i), if_inst_o, vt[i].e_v ? rom(vt[i].e_ipc) : 32'h0);
      end
    end
    branch_flag_i = 1'b0; flush_i = 1'b0;

    hits = 0;
    foreach (emitted[k]) if (emitted[k] == 32'h8 || emitted[k] == 32'hC) hits++;
    chk("wrong_path_emitted", 32'(hits), 32'h0);

    // PC wraps modulo 2^32
    if_ready_i = 1'b1; branch_flag_i = 1'b1; branch_tgt_i = 32'hFFFF_FFF8;
    step();
    branch_flag_i = 1'b0;
    step(); chk("wrap_pc1", pc, 32'hFFFF_FFFC); chk("wrap_head1", if_pc_o, 32'hFFFF_FFF8);
    step(); chk("wrap_pc2", pc, 32'h0);         chk("wrap_head2", if_pc_o, 32'hFFFF_FFFC);
    step(); chk("wrap_head3", if_pc_o, 32'h0);  chk("wrap_inst3", if_inst_o, 32'h100);
    step();

    // Reset mid-stream
    rst = 1'b0; step();
    chk("mrst_valid", 32'(if_valid_o), 32'h0); chk("mrst_pc", pc, 32'h0); chk("mrst_ce", 32'(ce), 32'h0);
    rst = 1'b1; step(); chk("mrst_ce1", 32'(ce), 32'h1);
    step(); chk("mrst_head", if_pc_o, 32'h0); chk("mrst_v", 32'(if_valid_o), 32'h1);
    step();

    // Misaligned branch target
    branch_flag_i = 1'b1; branch_tgt_i = 32'h42;
    step();
    branch_flag_i = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    chk("mis_err", 32'(fetch_err_o), 32'h1); chk("mis_ce", 32'(ce), 32'h0); chk("mis_pc", pc, 32'h42);
    repeat (3) step();
    chk("halt_err", 32'(fetch_err_o), 32'h1); chk("halt_v", 32'(if_valid_o), 32'h0);
    flush_i = 1'b1; new_pc_i = 32'h180;
    step();
    flush_i = 1'b0;
    chk("rec_err", 32'(fetch_err_o), 32'h0); chk("rec_ce", 32'(ce), 32'h1);
    step(); chk("rec_head", if_pc_o, 32'h180);
`else
    chk("mis_err", 32'(fetch_err_o), 32'h0); chk("mis_pc", pc, 32'h40); chk("mis_ce", 32'(ce), 32'h1);
    step(); chk("mis_head", if_pc_o, 32'h40);
`endif

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst           = ($urandom_range(0, 79) != 0);
      if_ready_i    = 1'($urandom_range(0, 1));
      branch_flag_i = ($urandom_range(0, 11) == 0);
      branch_tgt_i  = $urandom & 32'h0000_03FF;
      flush_i       = ($urandom_range(0, 15) == 0);
      new_pc_i      = ($urandom & 32'h0000_03FC) | (($urandom_range(0, 3) == 0) ? 32'h2 : 32'h0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
